referee_dist: RTL and testbench

- Receive-side counterpart of the 4-to-1 referee.
- Drains a single shared source FIFO whose words carry a 2-bit destination class, and distributes each word to one of four destination FIFOs (push_0..3).
- Honours the destination almost_full flags and keeps words strictly in order.
- Sits between the merged transaction FIFO and the four per-class egress FIFOs.

---
 rtl/referee_dist_pkg.sv | 14 +
 rtl/referee_dist_q.sv | 48 ++++
 rtl/referee_dist.sv | 94 +++++++++
 tb/tb_referee_dist.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/referee_dist_pkg.sv
// rtl/referee_dist_pkg.sv - shared word layout and class encodings for the referee pair
`timescale 1ns/1ps
package referee_dist_pkg;
  localparam int DATA_WIDTH  = 12;
  localparam int DEST_LSB    = 10;
  localparam int NUM_CLASSES = 4;

  typedef enum logic [1:0] {
    CLASS_0 = 2'd0,
    CLASS_1 = 2'd1,
    CLASS_2 = 2'd2,
    CLASS_3 = 2'd3
  } class_e;
endpackage

// File: rtl/referee_dist_q.sv
// rtl/referee_dist_q.sv - 2-entry in-order holding queue between source read and push
`timescale 1ns/1ps
module referee_dist_q #(
  parameter int W = referee_dist_pkg::DATA_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq,
  input  logic [W-1:0] enq_data,
  input  logic         deq,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   occ_q;
  logic [1:0]   occ_d;

  always_comb begin
    occ_d = occ_q;
    case ({enq, deq})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (enq) begin
        mem_q[wr_ptr_q] <= enq_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign occ  = occ_q;
endmodule

// File: rtl/referee_dist.sv
// rtl/referee_dist.sv - drains the merged source FIFO into four per-class egress FIFOs
`timescale 1ns/1ps
module referee_dist #(
  parameter int DATA_WIDTH = referee_dist_pkg::DATA_WIDTH,
  parameter int DEST_LSB   = referee_dist_pkg::DEST_LSB
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  empty_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  pop_in,
  input  logic                  almost_full_0,
  input  logic                  almost_full_1,
  input  logic                  almost_full_2,
  input  logic                  almost_full_3,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  push_0,
  output logic                  push_1,
  output logic                  push_2,
  output logic                  push_3,
  output logic                  idle
);
  import referee_dist_pkg::*;

  logic                   inflight_q;
  logic [NUM_CLASSES-1:0] push_q, push_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   idle_q, idle_d;

  logic [DATA_WIDTH-1:0]  head;
  logic [1:0]             occ;
  logic [1:0]             occ_next;
  logic [2:0]             fill_next;
  logic [NUM_CLASSES-1:0] af;
  class_e                 dest;
  logic                   deq;

  referee_dist_q #(.W(DATA_WIDTH)) u_q (
    .clk      (clk),
    .reset    (reset),
    .enq      (inflight_q),
    .enq_data (data_in),
    .deq      (deq),
    .head     (head),
    .occ      (occ)
  );

  assign af   = {almost_full_3, almost_full_2, almost_full_1, almost_full_0};
  assign dest = class_e'(head[DEST_LSB+1:DEST_LSB]);
  assign deq  = (occ != 2'd0) && !af[dest];

  // Counting the same-cycle dequeue lets a full queue still pop, keeping 1 word/cycle.
  assign fill_next = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, deq};
  assign pop_in    = reset & enable & ~empty_in & (fill_next < 3'd2);
  assign occ_next  = occ + {1'b0, inflight_q} - {1'b0, deq};

  always_comb begin
    push_d     = '0;
    data_out_d = data_out_q;
    if (deq) begin
      data_out_d = head;
      case (dest)
        CLASS_0: push_d = 4'b0001;
        CLASS_1: push_d = 4'b0010;
        CLASS_2: push_d = 4'b0100;
        CLASS_3: push_d = 4'b1000;
        default: push_d = '0;
      endcase
    end
    idle_d = (occ_next == 2'd0) && !pop_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      push_q     <= '0;
      data_out_q <= '0;
      idle_q     <= 1'b1;
    end else begin
      inflight_q <= pop_in;
      push_q     <= push_d;
      data_out_q <= data_out_d;
      idle_q     <= idle_d;
    end
  end

  assign data_out = data_out_q;
  assign push_0   = push_q[0];
  assign push_1   = push_q[1];
  assign push_2   = push_q[2];
  assign push_3   = push_q[3];
  assign idle     = idle_q;
endmodule

// File: tb/tb_referee_dist.sv
// tb/tb_referee_dist.sv - scoreboard bench for referee_dist with a registered-read source FIFO model
`timescale 1ns/1ps
module tb_referee_dist;
  import referee_dist_pkg::*;
  localparam int DW = DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          empty_in = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          pop_in;
  logic          af0 = 1'b0, af1 = 1'b0, af2 = 1'b0, af3 = 1'b0;
  logic [DW-1:0] data_out;
  logic          push_0, push_1, push_2, push_3;
  logic          idle;

  always #5 clk = ~clk;

  referee_dist dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .empty_in      (empty_in),
    .data_in       (data_in),
    .pop_in        (pop_in),
    .almost_full_0 (af0),
    .almost_full_1 (af1),
    .almost_full_2 (af2),
    .almost_full_3 (af3),
    .data_out      (data_out),
    .push_0        (push_0),
    .push_1        (push_1),
    .push_2        (push_2),
    .push_3        (push_3),
    .idle          (idle)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            pop_cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] src[$];
  int            push_cyc[$];
  int            checks = 0, errors = 0;
  int            cyc = 0, pops = 0, pushes = 0;
  bit            lat_exact = 1'b1;
  bit            pop_seen = 1'b0;
  logic [3:0]    pv;
  exp_t          e;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source FIFO: a pop sampled at edge N presents its word from just after edge N.
  always @(posedge clk) begin
    cyc++;
    #2;
    if (pop_seen && src.size() > 0) data_in = src.pop_front();
    pop_seen = 1'b0;
    empty_in = (src.size() == 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      if (pop_in) begin
        pop_seen = 1'b1;
        pops++;
        if (src.size() > 0) sb.push_back('{src[0], cyc + 1});
      end
      pv = {push_3, push_2, push_1, push_0};
      if (pv != 4'b0) begin
        pushes++;
        push_cyc.push_back(cyc);
        check("push_onehot", $countones(pv), 1);
        if (sb.size() == 0) begin
          check("unexpected_push", int'(pv), 0);
        end else begin
          e = sb.pop_front();
          check("data_out", int'(data_out), int'(e.data));
          check("push_dest", int'(pv), int'(4'b0001 << e.data[DEST_LSB+1:DEST_LSB]));
          if (lat_exact) check("latency", cyc - e.pop_cyc, 2);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick(1);
      n++;
    end
    check({tag, "_drain"}, sb.size(), 0);
  endtask

  function automatic logic [DW-1:0] mkword(input int dest, input int payload);
    logic [DW-1:0] w;
    w = DW'(payload);
    w[DEST_LSB+1:DEST_LSB] = 2'(dest);
    return w;
  endfunction

  int base;

  initial begin
    // Reset with a word already waiting in the source
    src.push_back(12'hC05);
    enable = 1'b1;
    tick(3);
    check("rst_pop_in", pop_in, 0);
    check("rst_push", int'({push_3, push_2, push_1, push_0}), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_idle", idle, 1);
    reset = 1'b1;
    #1;
    check("release_pop_in", pop_in, 1);
    tick(1);
    wait_drain("single", 10);
    check("single_pushes", pushes, 1);
    check("single_idle", idle, 1);

    // Streaming, no back-pressure
    base = pops;
    push_cyc.delete();
    for (int i = 0; i < 8; i++) src.push_back(mkword(i % 4, i * 37 + 5));
    tick(2);
    wait_drain("stream", 30);
    check("stream_pops", pops - base, 8);
    check("stream_push_count", push_cyc.size(), 8);
    if (push_cyc.size() == 8) check("stream_span", push_cyc[7] - push_cyc[0], 7);
    check("stream_idle", idle, 1);

    // Head-of-line blocking on class 1
    lat_exact = 1'b0;
    af1 = 1'b1;
    base = pushes;
    src.push_back(12'h400);
    src.push_back(12'h001);
    src.push_back(12'h802);
    tick(8);
    check("hol_no_push", pushes - base, 0);
    check("hol_pop_blocked", pop_in, 0);
    check("hol_idle", idle, 0);
    push_cyc.delete();
    af1 = 1'b0;
    tick(1);
    wait_drain("hol", 20);
    check("hol_push_count", push_cyc.size(), 3);
    if (push_cyc.size() >= 2) check("hol_back_to_back", push_cyc[1] - push_cyc[0], 1);

    // Enable dropped after two pops
    lat_exact = 1'b1;
    enable = 1'b0;
    base = pops;
    for (int i = 0; i < 4; i++) src.push_back(mkword(i, 16'h0AA + i));
    tick(2);
    check("en_low_no_pop", pop_in, 0);
    enable = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(1);
    wait_drain("enable", 10);
    tick(4);
    check("en_pops", pops - base, 2);
    check("en_pop_in", pop_in, 0);
    check("en_idle", idle, 1);
    src.delete();
    tick(1);
    enable = 1'b1;
    tick(1);

    // Async reset with a full holding queue
    lat_exact = 1'b0;
    af0 = 1'b1;
    src.push_back(12'h011);
    src.push_back(12'h022);
    src.push_back(12'h033);
    tick(6);
    check("pre_rst_pop_blocked", pop_in, 0);
    check("pre_rst_idle", idle, 0);
    reset = 1'b0;
    #1;
    check("async_data_out", int'(data_out), 0);
    check("async_idle", idle, 1);
    check("async_pop_in", pop_in, 0);
    check("async_push", int'({push_3, push_2, push_1, push_0}), 0);
    sb.delete();
    src.delete();
    af0 = 1'b0;
    tick(3);
    reset = 1'b1;
    base = pushes;
    tick(10);
    check("post_rst_no_push", pushes - base, 0);
    check("post_rst_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
